r0_arith_unit: RTL and testbench

R0_ARITH_UNIT -- requirements
Module: r0_arith_unit

---
 rtl/r0_arith_unit.sv | 153 +++++++++++++++
 tb/tb_r0_arith_unit.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/r0_arith_unit.sv
// Multi-cycle arithmetic unit: single-cycle ADD/SUB/NEG, iterative Booth or shift-add MUL.
// Define ALU_FLAGS_EN to add the registered {Z,N,C,V} flags output.
module r0_arith_unit #(
  parameter int WIDTH      = 8,
  parameter bit MUL_SIGNED = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             start,
  input  logic [1:0]       state,
  input  logic [WIDTH-1:0] value1,
  input  logic [WIDTH-1:0] value2,
  output logic [WIDTH-1:0] Output1,
  output logic [WIDTH-1:0] Output2,
  output logic             busy,
  output logic             ready
`ifdef ALU_FLAGS_EN
  ,
  output logic [3:0]       flags
`endif
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_MUL} fsm_e;
  typedef enum logic [1:0] {OP_ADD, OP_SUB, OP_MUL, OP_NEG} op_e;

  fsm_e             r_state, w_next;
  op_e              r_op;
  logic [WIDTH-1:0] r_a, r_b;
  logic [WIDTH:0]   r_acc;
  logic             r_qm1;
  logic [CW-1:0]    r_cnt;

  logic [WIDTH:0]     w_m_ext, w_step, w_acc_next;
  logic [WIDTH-1:0]   w_q_next;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_b_eff, w_res;
  logic [WIDTH:0]     w_sum;
  logic               w_c, w_v;
  logic               w_mul_done;

  assign busy       = (r_state != S_IDLE);
  assign w_mul_done = (r_state == S_MUL) && (r_cnt == '0);

  // NOTE: every always_comb assigns its outputs a default first, so no path can infer a latch.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = (op_e'(state) == OP_MUL) ? S_MUL : S_EXEC;
      S_EXEC:  w_next = S_IDLE;
      S_MUL:   if (r_cnt == '0) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // One multiply step; accumulator carries an extra bit so A-M/A+M never wraps.
  always_comb begin
    w_m_ext = MUL_SIGNED ? {r_a[WIDTH-1], r_a} : {1'b0, r_a};
    w_step  = r_acc;
    if (MUL_SIGNED) begin
      case ({r_b[0], r_qm1})
        2'b01:   w_step = r_acc + w_m_ext;
        2'b10:   w_step = r_acc - w_m_ext;
        default: w_step = r_acc;
      endcase
    end else if (r_b[0]) begin
      w_step = r_acc + w_m_ext;
    end
    w_acc_next = {(MUL_SIGNED ? w_step[WIDTH] : 1'b0), w_step[WIDTH:1]};
    w_q_next   = {w_step[0], r_b[WIDTH-1:1]};
  end

  // Multiplier bits shift out of r_b as the low product half shifts in.
  assign w_prod = {r_acc[WIDTH-1:0], r_b};

  // SUB reuses the adder as a + ~b + 1, so carry and overflow share one expression.
  always_comb begin
    w_b_eff = (r_op == OP_SUB) ? ~r_b : r_b;
    w_sum   = {1'b0, r_a} + {1'b0, w_b_eff} + {{WIDTH{1'b0}}, (r_op == OP_SUB)};
    w_res   = w_sum[WIDTH-1:0];
    w_c     = w_sum[WIDTH];
    w_v     = (r_a[WIDTH-1] == w_b_eff[WIDTH-1]) && (w_res[WIDTH-1] != r_a[WIDTH-1]);
    if (r_op == OP_NEG) begin
      w_res = ~r_a + 1'b1;
      w_c   = 1'b0;
      w_v   = (r_a == MIN_NEG);
    end
  end

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  r_state <= S_IDLE;
    else if (en) r_state <= w_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op  <= OP_ADD;
      r_a   <= '0;
      r_b   <= '0;
      r_acc <= '0;
      r_qm1 <= 1'b0;
      r_cnt <= '0;
    end else if (en) begin
      if (r_state == S_IDLE && start) begin
        r_op  <= op_e'(state);
        r_a   <= value1;
        r_b   <= value2;
        r_acc <= '0;
        r_qm1 <= 1'b0;
        r_cnt <= CW'(WIDTH);
      end else if (r_state == S_MUL && r_cnt != '0) begin
        r_acc <= w_acc_next;
        r_b   <= w_q_next;
        r_qm1 <= r_b[0];
        r_cnt <= r_cnt - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Output1 <= '0;
      Output2 <= '0;
      ready   <= 1'b0;
`ifdef ALU_FLAGS_EN
      flags   <= 4'b0000;
`endif
    end else if (en) begin
      ready <= 1'b0;
      if (r_state == S_EXEC) begin
        Output1 <= w_res;
        Output2 <= '0;
        ready   <= 1'b1;
`ifdef ALU_FLAGS_EN
        flags <= {(w_res == '0), w_res[WIDTH-1],
                  (r_op != OP_NEG) && w_c, w_v};
`endif
      end else if (w_mul_done) begin
        Output1 <= w_prod[2*WIDTH-1:WIDTH];
        Output2 <= w_prod[WIDTH-1:0];
        ready   <= 1'b1;
`ifdef ALU_FLAGS_EN
        flags <= {(w_prod == '0), w_prod[2*WIDTH-1], 1'b0, 1'b0};
`endif
      end
    end
  end

endmodule

// File: tb/tb_r0_arith_unit.sv
// Scoreboard bench for r0_arith_unit (WIDTH=8, signed multiply); flag checks when ALU_FLAGS_EN is defined.
module tb_r0_arith_unit;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         en = 1'b1;
  logic         start = 1'b0;
  logic [1:0]   state = 2'd0;
  logic [W-1:0] value1 = '0;
  logic [W-1:0] value2 = '0;
  logic [W-1:0] Output1, Output2;
  logic         busy, ready;
  logic [3:0]   flags;

  typedef struct {
    string        tag;
    logic [W-1:0] o1;
    logic [W-1:0] o2;
    logic [3:0]   fl;
    int           edge_n;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   edge_n   = 0;

  r0_arith_unit #(.WIDTH(W), .MUL_SIGNED(1'b1)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (en),
    .start  (start),
    .state  (state),
    .value1 (value1),
    .value2 (value2),
    .Output1(Output1),
    .Output2(Output2),
    .busy   (busy),
    .ready  (ready)
`ifdef ALU_FLAGS_EN
    ,
    .flags  (flags)
`endif
  );

`ifndef ALU_FLAGS_EN
  assign flags = 4'b0000;
`endif

  always #5 clk = ~clk;
  always @(posedge clk) edge_n <= edge_n + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  // Reference results from plain integer arithmetic.
  function automatic exp_t model(string tag, logic [1:0] op, logic [W-1:0] a, logic [W-1:0] b,
                                 int ready_edge);
    exp_t         e;
    int           sa, sb_i, r;
    logic [31:0]  t;
    logic [W-1:0] nb;
    logic         z, n, c, v;
    sa   = int'($signed(a));
    sb_i = int'($signed(b));
    e.tag = tag;
    e.edge_n = ready_edge;
    e.o2 = '0;
    c = 1'b0;
    v = 1'b0;
    case (op)
      2'd0: begin
        t    = 32'(a) + 32'(b);
        e.o1 = t[W-1:0];
        c    = t[W];
        r    = sa + sb_i;
        v    = (r > 127) || (r < -128);
      end
      2'd1: begin
        nb   = ~b;
        t    = 32'(a) + 32'(nb) + 32'd1;
        e.o1 = t[W-1:0];
        c    = t[W];
        r    = sa - sb_i;
        v    = (r > 127) || (r < -128);
      end
      2'd2: begin
        t    = 32'(sa * sb_i);
        e.o1 = t[2*W-1:W];
        e.o2 = t[W-1:0];
      end
      default: begin
        t    = 32'(-sa);
        e.o1 = t[W-1:0];
        v    = (a == 8'h80);
      end
    endcase
    z = ({e.o1, e.o2} == '0);
    n = e.o1[W-1];
    e.fl = {z, n, c, v};
    return e;
  endfunction

  always @(negedge clk) begin
    if (rst_n && ready) begin
      if (sb.size() == 0) begin
        check("spurious_ready", 32'(ready), 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check({e.tag, "_out1"}, 32'(Output1), 32'(e.o1));
        check({e.tag, "_out2"}, 32'(Output2), 32'(e.o2));
        check({e.tag, "_edge"}, 32'(edge_n), 32'(e.edge_n));
`ifdef ALU_FLAGS_EN
        check({e.tag, "_flags"}, 32'(flags), 32'(e.fl));
`endif
      end
    end
  end

  // Holds start for one edge; operands are scrambled right after acceptance.
  task automatic issue(string tag, logic [1:0] op, logic [W-1:0] a, logic [W-1:0] b,
                       bit expect_acc, int stall);
    state  = op;
    value1 = a;
    value2 = b;
    start  = 1'b1;
    @(posedge clk);
    #1;
    if (expect_acc)
      sb.push_back(model(tag, op, a, b, edge_n + ((op == 2'd2) ? W + 1 : 1) + stall));
    start  = 1'b0;
    state  = ~op;
    value1 = ~a;
    value2 = ~b;
  endtask

  task automatic drain(string tag);
    for (int i = 0; i < 40 && sb.size() != 0; i++) begin
      @(negedge clk);
      #1;
    end
    check({tag, "_drained"}, 32'(sb.size()), 32'd0);
  endtask

  initial begin
    #2;
    check("rst_out1", 32'(Output1), 32'd0);
    check("rst_out2", 32'(Output2), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ready", 32'(ready), 32'd0);
    #10;
    rst_n = 1'b1;

    // first start right after reset release
    issue("add_200_100", 2'd0, 8'd200, 8'd100, 1'b1, 0);
    check("exec_busy", 32'(busy), 32'd1);
    drain("add_200_100");
    issue("sub_5_7", 2'd1, 8'd5, 8'd7, 1'b1, 0);
    drain("sub_5_7");
    issue("neg_min", 2'd3, 8'h80, 8'h00, 1'b1, 0);
    drain("neg_min");
    issue("neg_zero", 2'd3, 8'h00, 8'h33, 1'b1, 0);
    drain("neg_zero");
    issue("add_ovf", 2'd0, 8'h7F, 8'h01, 1'b1, 0);
    drain("add_ovf");
    issue("sub_eq", 2'd1, 8'h9C, 8'h9C, 1'b1, 0);
    drain("sub_eq");

    issue("mul_m128sq", 2'd2, 8'h80, 8'h80, 1'b1, 0);
    drain("mul_m128sq");
    issue("mul_m3x5", 2'd2, 8'hFD, 8'h05, 1'b1, 0);
    drain("mul_m3x5");
    issue("mul_127xm127", 2'd2, 8'h7F, 8'h81, 1'b1, 0);
    drain("mul_127xm127");

    // start while busy is dropped; start during ready is accepted
    issue("mul_busy", 2'd2, 8'h12, 8'h34, 1'b1, 0);
    repeat (2) @(posedge clk);
    #1;
    check("busy_mid_mul", 32'(busy), 32'd1);
    state  = 2'd0;
    value1 = 8'h01;
    value2 = 8'h01;
    start  = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int i = 0; i < 20 && !ready; i++) @(negedge clk);
    check("b2b_ready_seen", 32'(ready), 32'd1);
    issue("add_b2b", 2'd0, 8'h0F, 8'hF1, 1'b1, 0);
    drain("add_b2b");

    // three-cycle enable stall inside a multiply
    issue("mul_stall", 2'd2, 8'hFD, 8'h05, 1'b1, 3);
    repeat (2) @(posedge clk);
    #1;
    en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("stall_busy", 32'(busy), 32'd1);
    en = 1'b1;
    drain("mul_stall");

    // reset mid-multiply abandons it
    issue("mul_rst", 2'd2, 8'h55, 8'h66, 1'b0, 0);
    repeat (2) @(posedge clk);
    #1;
    check("pre_rst_busy", 32'(busy), 32'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_out1", 32'(Output1), 32'd0);
    check("mid_rst_out2", 32'(Output2), 32'd0);
    check("mid_rst_ready", 32'(ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (15) @(posedge clk);
    #1;
    check("post_rst_idle", 32'(busy), 32'd0);
    issue("add_after_rst", 2'd0, 8'h10, 8'h20, 1'b1, 0);
    drain("add_after_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
